// File: rtl/bcd_updown_cnt.sv
// Multi-digit BCD up/down counter stepped by debounced key edge pulses, with clear, checked load and wrap pulse.
// Optional hold-to-repeat is built when BCD_CNT_AUTOREPEAT_EN is defined.
module bcd_updown_cnt #(
    parameter int                  DIGITS     = 2,
    parameter logic [4*DIGITS-1:0] MAX_VAL    = 8'h99,
    parameter int                  REPEAT_DLY = 25_000_000,
    parameter int                  REPEAT_PER = 5_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_up_rise,
    input  logic                key_dn_rise,
    input  logic                key_up_lvl,
    input  logic                key_dn_lvl,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] cnt_out,
    output logic                wrap_pulse,
    output logic                load_err
);
    localparam int W    = 4 * DIGITS;
    localparam int TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int TW   = $clog2(TMAX + 1);

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // With every nibble <= 9 a plain binary compare orders BCD values correctly.
    function automatic logic load_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok && (v <= MAX_VAL);
    endfunction

    logic rise_up, rise_dn, rep_up, rep_dn, do_up, do_dn;

    assign rise_up = key_up_rise & ~key_dn_rise;
    assign rise_dn = key_dn_rise & ~key_up_rise;

`ifdef BCD_CNT_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    localparam logic [TW-1:0] DLY_TC = TW'(REPEAT_DLY - 1);
    localparam logic [TW-1:0] PER_TC = TW'(REPEAT_PER - 1);

    rpt_state_t    state;
    logic          dir_up;
    logic [TW-1:0] timer;
    logic          lvl_ok, fire, blocked;

    assign lvl_ok  = (dir_up ? key_up_lvl : key_dn_lvl) & ~(key_up_lvl & key_dn_lvl);
    assign fire    = lvl_ok & (((state == DELAY) && (timer == DLY_TC)) ||
                               ((state == REPEAT) && (timer == PER_TC)));
    assign blocked = clr | load | key_up_rise | key_dn_rise;
    assign rep_up  = fire & dir_up & ~blocked;
    assign rep_dn  = fire & ~dir_up & ~blocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            dir_up <= 1'b0;
            timer  <= '0;
        end else if (clr || load) begin
            state <= IDLE;
            timer <= '0;
        end else if (rise_up || rise_dn) begin
            state  <= DELAY;
            dir_up <= rise_up;
            timer  <= '0;
        end else begin
            case (state)
                DELAY: begin
                    if (!lvl_ok) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == DLY_TC) begin
                        state <= REPEAT;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!lvl_ok) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == PER_TC) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{key_up_lvl, key_dn_lvl, TW[0]};
    assign rep_up     = 1'b0;
    assign rep_dn     = 1'b0;
`endif

    assign do_up = rise_up | rep_up;
    assign do_dn = rise_dn | rep_dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_out    <= '0;
            wrap_pulse <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            load_err   <= 1'b0;
            if (clr) begin
                cnt_out <= '0;
            end else if (load) begin
                if (load_ok(load_val)) cnt_out <= load_val;
                else                   load_err <= 1'b1;
            end else if (do_up) begin
                if (cnt_out == MAX_VAL) begin
                    cnt_out    <= '0;
                    wrap_pulse <= 1'b1;
                end else begin
                    cnt_out <= bcd_inc(cnt_out);
                end
            end else if (do_dn) begin
                if (cnt_out == '0) begin
                    cnt_out    <= MAX_VAL;
                    wrap_pulse <= 1'b1;
                end else begin
                    cnt_out <= bcd_dec(cnt_out);
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_updown_cnt.sv
// Self-checking bench for bcd_updown_cnt: vector table on a 2-digit counter plus hand sequences
// on 3-digit and MAX_VAL=59 instances; repeat sequences when BCD_CNT_AUTOREPEAT_EN is defined.
module tb_bcd_updown_cnt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       up2 = 0, dn2 = 0, ul2 = 0, dl2 = 0, clr2 = 0, ld2 = 0;
    logic [7:0] lv2 = 0, cnt2;
    logic       wrap2, err2;

    logic        up3 = 0, dn3 = 0, clr3 = 0, ld3 = 0;
    logic [11:0] lv3 = 0, cnt3;
    logic        wrap3, err3;

    logic       up5 = 0, dn5 = 0, clr5 = 0, ld5 = 0;
    logic [7:0] lv5 = 0, cnt5;
    logic       wrap5, err5;

    bcd_updown_cnt #(.DIGITS(2), .MAX_VAL(8'h99), .REPEAT_DLY(10), .REPEAT_PER(4)) u2 (
        .clk(clk), .rst(rst), .key_up_rise(up2), .key_dn_rise(dn2),
        .key_up_lvl(ul2), .key_dn_lvl(dl2), .clr(clr2), .load(ld2), .load_val(lv2),
        .cnt_out(cnt2), .wrap_pulse(wrap2), .load_err(err2));

    bcd_updown_cnt #(.DIGITS(3), .MAX_VAL(12'h359), .REPEAT_DLY(10), .REPEAT_PER(4)) u3 (
        .clk(clk), .rst(rst), .key_up_rise(up3), .key_dn_rise(dn3),
        .key_up_lvl(1'b0), .key_dn_lvl(1'b0), .clr(clr3), .load(ld3), .load_val(lv3),
        .cnt_out(cnt3), .wrap_pulse(wrap3), .load_err(err3));

    bcd_updown_cnt #(.DIGITS(2), .MAX_VAL(8'h59), .REPEAT_DLY(10), .REPEAT_PER(4)) u5 (
        .clk(clk), .rst(rst), .key_up_rise(up5), .key_dn_rise(dn5),
        .key_up_lvl(1'b0), .key_dn_lvl(1'b0), .clr(clr5), .load(ld5), .load_val(lv5),
        .cnt_out(cnt5), .wrap_pulse(wrap5), .load_err(err5));

    typedef struct {
        logic       up, dn, clr, load;
        logic [7:0] lv;
        logic [7:0] cnt;
        logic       wrap, err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd2(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // Drive u2 inputs for one cycle, sample just after the edge, then release the pulses.
    task automatic cyc2(input logic up, input logic dn, input logic c, input logic ld, input logic [7:0] lv);
        @(negedge clk);
        up2 = up; dn2 = dn; clr2 = c; ld2 = ld; lv2 = lv;
        @(posedge clk);
        #1;
        up2 = 0; dn2 = 0; clr2 = 0; ld2 = 0;
    endtask

    task automatic cyc3(input logic dn, input logic ld, input logic [11:0] lv);
        @(negedge clk);
        dn3 = dn; ld3 = ld; lv3 = lv;
        @(posedge clk);
        #1;
        dn3 = 0; ld3 = 0;
    endtask

    task automatic cyc_lvl(input logic up, input logic dn, input logic ul, input logic dl, input logic c);
        @(negedge clk);
        up2 = up; dn2 = dn; ul2 = ul; dl2 = dl; clr2 = c;
        @(posedge clk);
        #1;
        up2 = 0; dn2 = 0; clr2 = 0;
    endtask

    initial begin
        int wraps;
        int exp_v;
        vecs[0]  = '{0, 0, 0, 1, 8'h42, 8'h42, 0, 0};
        vecs[1]  = '{0, 0, 0, 1, 8'h5A, 8'h42, 0, 1};
        vecs[2]  = '{0, 0, 0, 1, 8'hA0, 8'h42, 0, 1};
        vecs[3]  = '{1, 0, 0, 0, 8'h00, 8'h43, 0, 0};
        vecs[4]  = '{1, 1, 0, 0, 8'h00, 8'h43, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 8'h00, 8'h42, 0, 0};
        vecs[6]  = '{1, 0, 1, 1, 8'h15, 8'h00, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 8'h00, 8'h99, 1, 0};
        vecs[8]  = '{1, 0, 0, 0, 8'h00, 8'h00, 1, 0};
        vecs[9]  = '{0, 0, 0, 1, 8'h99, 8'h99, 0, 0};
        vecs[10] = '{1, 0, 0, 1, 8'h10, 8'h10, 0, 0};
        vecs[11] = '{0, 1, 0, 0, 8'h00, 8'h09, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 8'h00, 8'h10, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 8'h00, 8'h10, 0, 0};
        vecs[14] = '{1, 0, 0, 1, 8'h5A, 8'h10, 0, 1};
        vecs[15] = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cnt2", cnt2, 8'h00);
        chk("reset_wrap2", wrap2, 0);
        chk("reset_err2", err2, 0);
        chk("reset_cnt3", cnt3, 12'h000);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 16; i++) begin
            cyc2(vecs[i].up, vecs[i].dn, vecs[i].clr, vecs[i].load, vecs[i].lv);
            chk($sformatf("vec%0d_cnt", i), cnt2, vecs[i].cnt);
            chk($sformatf("vec%0d_wrap", i), wrap2, vecs[i].wrap);
            chk($sformatf("vec%0d_err", i), err2, vecs[i].err);
        end

        // 100 back-to-back up pulses from 00
        wraps = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc2(1, 0, 0, 0, 8'h00);
            chk($sformatf("up100_cnt%0d", k), cnt2, to_bcd2(k % 100));
            if (wrap2) wraps++;
            if (k == 100) chk("up100_wrap_last", wrap2, 1);
        end
        chk("up100_wrap_count", wraps, 1);
        cyc2(0, 0, 0, 0, 8'h00);
        chk("wrap_one_cycle", wrap2, 0);

        // 3-digit, MAX 359
        cyc3(1, 0, 12'h000);
        chk("d3_wrap_cnt", cnt3, 12'h359);
        chk("d3_wrap_pulse", wrap3, 1);
        cyc3(1, 0, 12'h000);
        chk("d3_dn_cnt", cnt3, 12'h358);
        chk("d3_dn_nowrap", wrap3, 0);
        cyc3(0, 1, 12'h100);
        chk("d3_load", cnt3, 12'h100);
        cyc3(1, 0, 12'h000);
        chk("d3_borrow", cnt3, 12'h099);
        cyc3(0, 1, 12'h360);
        chk("d3_load_over", cnt3, 12'h099);
        chk("d3_load_over_err", err3, 1);

        // MAX 59 rejects 60
        @(negedge clk);
        ld5 = 1; lv5 = 8'h60;
        @(posedge clk);
        #1;
        ld5 = 0;
        chk("m59_load60_cnt", cnt5, 8'h00);
        chk("m59_load60_err", err5, 1);
        @(negedge clk);
        up5 = 1;
        @(posedge clk);
        #1;
        up5 = 0;
        chk("m59_up", cnt5, 8'h01);

        // async reset between pulses
        cyc2(0, 0, 0, 1, 8'h42);
        chk("pre_rst", cnt2, 8'h42);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        chk("rst_async_cnt", cnt2, 8'h00);
        chk("rst_async_cnt3", cnt3, 12'h000);
        @(negedge clk);
        rst = 0;

`ifdef BCD_CNT_AUTOREPEAT_EN
        // up held 30 cycles from 05: steps at edges 0,10,14,18,22,26
        cyc2(0, 0, 0, 1, 8'h05);
        exp_v = 5;
        for (int n = 0; n < 35; n++) begin
            cyc_lvl(n == 0, 0, n < 30, 0, 0);
            if (n == 0 || n == 10 || n == 14 || n == 18 || n == 22 || n == 26) exp_v++;
            chk($sformatf("rpt_up_e%0d", n), cnt2, to_bcd2(exp_v));
        end
        chk("rpt_up_final", cnt2, 8'h11);

        // reversal during REPEAT
        cyc2(0, 0, 0, 1, 8'h50);
        exp_v = 50;
        for (int n = 0; n < 29; n++) begin
            if (n < 13) cyc_lvl(n == 0, 0, 1, 0, 0);
            else        cyc_lvl(0, n == 13, 0, 1, 0);
            if (n == 0 || n == 10) exp_v++;
            if (n == 13 || n == 23 || n == 27) exp_v--;
            chk($sformatf("rpt_rev_e%0d", n), cnt2, to_bcd2(exp_v));
        end
        cyc_lvl(0, 0, 0, 0, 0);

        // clr during DELAY ends repeating
        cyc2(0, 0, 0, 1, 8'h49);
        for (int n = 0; n < 21; n++) begin
            cyc_lvl(n == 0, 0, 1, 0, n == 3);
            chk($sformatf("rpt_clr_e%0d", n), cnt2, (n < 3) ? 8'h50 : 8'h00);
        end
        cyc_lvl(0, 0, 0, 0, 0);
`else
        // without repeat support a held level adds nothing beyond the rise pulse
        cyc2(0, 0, 0, 1, 8'h05);
        for (int n = 0; n < 15; n++) begin
            cyc_lvl(n == 0, 0, 1, 0, 0);
            chk($sformatf("norpt_e%0d", n), cnt2, 8'h06);
        end
        cyc_lvl(0, 0, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
